mmio_uart_tx: RTL

- Memory-mapped UART transmitter on the CPU data-memory bus, in parallel with the data RAM; the top-level address decode drives `we` only when the address hits this block's window.
- CPU stores queue bytes into a FIFO; a baud-rate FSM serialises them onto `tx` as 8N1 frames.
- Reads return status and the divisor, giving programs a print/debug channel observable in simulation.

---
 rtl/cpu_types.sv | 31 +++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/mmio_uart_tx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types.sv
// rtl/cpu_types.sv - shared CPU-side types and constants for the UART transmitter
package cpu_types;

  // Transmitter FSM states; PARITY is only reachable with MMIO_UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Register offsets inside the UART window
  localparam logic [31:0] UART_TXDATA_OFF = 32'h0;
  localparam logic [31:0] UART_STATUS_OFF = 32'h4;
  localparam logic [31:0] UART_BAUD_OFF   = 32'h8;

  // STATUS bit positions
  localparam int ST_FULL_BIT      = 0;
  localparam int ST_EMPTY_BIT     = 1;
  localparam int ST_BUSY_BIT      = 2;
  localparam int ST_OVERFLOW_BIT  = 3;
  localparam int ST_PARITY_BIT    = 4;
  localparam int ST_COUNT_LSB     = 8;

  // Even parity over a data byte: the bit that makes the total count of ones even
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count, shared by TX and a future RX path
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  // Pointer and count next-state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter; MMIO_UART_PARITY_EN adds an even-parity bit
module mmio_uart_tx
  import cpu_types::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic        we,
  input  logic [3:0]  write_byte_enable,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  output logic        irq_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef MMIO_UART_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  logic [29:0]   off_word;
  logic          hit_txdata, hit_status, hit_baud;
  logic          push_req, ovf_set, ovf_clr;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_rdata;
  logic          busy;

  uart_state_t   state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   baud_q, baud_d;
  logic [15:0]   baud_wr_val;
  logic          ovf_q, ovf_d;
`ifdef MMIO_UART_PARITY_EN
  logic          par_q, par_d;
`endif

  logic unused_bits;
  assign unused_bits = ^{wd[31:16], write_byte_enable[3:2]};

  // Word decode; the byte offset within a word is ignored
  assign off_word   = 30'((a - BASE_ADDR) >> 2);
  assign hit_txdata = (off_word == 30'(UART_TXDATA_OFF >> 2));
  assign hit_status = (off_word == 30'(UART_STATUS_OFF >> 2));
  assign hit_baud   = (off_word == 30'(UART_BAUD_OFF >> 2));

  assign push_req  = we & hit_txdata & write_byte_enable[0];
  assign fifo_pop  = (state_q == IDLE) & ~fifo_empty;
  assign ovf_set   = push_req & fifo_full & ~fifo_pop;
  assign ovf_clr   = we & hit_status & write_byte_enable[0] & wd[ST_OVERFLOW_BIT];
  assign busy      = (state_q != IDLE);
  assign irq_empty = fifo_empty & ~busy;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (wd[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Register writes: per-lane divisor update (zero stored as 1) and sticky overflow
  always_comb begin
    baud_wr_val = baud_q;
    if (write_byte_enable[0]) baud_wr_val[7:0]  = wd[7:0];
    if (write_byte_enable[1]) baud_wr_val[15:8] = wd[15:8];
    baud_d = baud_q;
    if (we && hit_baud) baud_d = (baud_wr_val == 16'd0) ? 16'd1 : baud_wr_val;
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
  end

  // Frame sequencer: every bit boundary reloads the counter from the current divisor
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef MMIO_UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          shift_d = fifo_rdata;
          cnt_d   = baud_q;
          bit_d   = 3'd0;
`ifdef MMIO_UART_PARITY_EN
          par_d   = even_parity(fifo_rdata);
`endif
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == 16'd1) begin
          cnt_d   = baud_q;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd1) begin
          cnt_d   = baud_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef MMIO_UART_PARITY_EN
      PARITY: begin
        if (cnt_q == 16'd1) begin
          cnt_d   = baud_q;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == 16'd1) begin
          cnt_d   = baud_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line driver decoded from state so reset forces idle-high immediately
  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
`ifdef MMIO_UART_PARITY_EN
      PARITY:  tx = par_q;
`endif
      default: tx = 1'b1;
    endcase
  end

  // Read mux, combinational from the address
  always_comb begin
    rd = 32'h0;
    if (hit_status) begin
      rd[ST_FULL_BIT]                  = fifo_full;
      rd[ST_EMPTY_BIT]                 = fifo_empty;
      rd[ST_BUSY_BIT]                  = busy;
      rd[ST_OVERFLOW_BIT]              = ovf_q;
      rd[ST_PARITY_BIT]                = PARITY_EN;
      rd[ST_COUNT_LSB+7:ST_COUNT_LSB]  = 8'(fifo_count);
    end else if (hit_baud) begin
      rd[15:0] = baud_q;
    end
  end

  // State, datapath and register flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= DEFAULT_DIV;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      baud_q  <= DEFAULT_DIV;
      ovf_q   <= 1'b0;
`ifdef MMIO_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      ovf_q   <= ovf_d;
`ifdef MMIO_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
